serial_subtractor: RTL

- Bit-serial two's-complement subtractor.
- Computes difference = a - b one bit per clock, LSB first, through a single full-adder cell with b inverted and the initial carry set to 1.
- Companion to the combinational full adder: it is the subtract direction of the same arithmetic, trading area for latency.
- Used by the multi-cycle datapath wherever a narrow-area subtract/compare is acceptable.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_fa_cell.sv | 24 ++
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : State encoding and default width for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fa_cell.sv
// ============================================================================
// Module   : serial_fa_cell
// Purpose  : One-bit structural full adder used as the serial arithmetic cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_cell (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    logic a_xor_b;

    assign a_xor_b  = a ^ b;
    assign sum      = a_xor_b ^ carryin;
    assign carryout = (a & b) | (a_xor_b & carryin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement a - b, LSB first, one bit per clock.
//            Define SERIAL_SUB_ADD_MODE_EN to add an op_add input (a + b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op_add,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             zacc;
    logic             a_sign;
    logic             b_sign;
    logic             invert_b;
    logic             invert_b_in;
    logic             accept;
    logic             fa_sum;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;
    logic             zacc_next;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic add_q;
    assign invert_b    = ~add_q;
    assign invert_b_in = ~op_add;
`else
    assign invert_b    = 1'b1;
    assign invert_b_in = 1'b1;
`endif

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign res_next  = {fa_sum, res_sh[WIDTH-1:1]};
    assign zacc_next = zacc & ~fa_sum;

    serial_fa_cell u_fa (
        .sum      (fa_sum),
        .carryout (fa_co),
        .a        (a_sh[0]),
        .b        (b_sh[0] ^ invert_b),
        .carryin  (carry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            zacc       <= 1'b0;
            a_sign     <= 1'b0;
            b_sign     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q      <= 1'b0;
`endif
        end else begin
            // Capture is shared by the IDLE and DONE (back-to-back) paths.
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                a_sign <= a[WIDTH-1];
                b_sign <= b[WIDTH-1];
                carry  <= invert_b_in;
                cnt    <= '0;
                zacc   <= 1'b1;
`ifdef SERIAL_SUB_ADD_MODE_EN
                add_q  <= op_add;
`endif
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= fa_co;
                    zacc   <= zacc_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        difference <= res_next;
                        borrow_out <= fa_co ^ invert_b;
                        zero       <= zacc_next;
                        // Subtract overflows on differing signs, add on equal signs.
                        overflow   <= ((a_sign ^ b_sign) == invert_b) &&
                                      (res_next[WIDTH-1] != a_sign);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
